// File: rtl/seller_pkg.sv
// seller_pkg: coin codes, coin values and FSM state encodings shared by the seller_ctrl slice
package seller_pkg;
  typedef enum logic [1:0] {
    COIN_1   = 2'b00,
    COIN_5   = 2'b01,
    COIN_10  = 2'b10,
    COIN_BAD = 2'b11
  } coin_e;
  localparam logic [3:0] VAL_1 = 4'd1;
  localparam logic [3:0] VAL_5 = 4'd5;
  localparam logic [3:0] VAL_10 = 4'd10;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_VEND = 3'd2;
  localparam logic [2:0] ST_CHANGE = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  function automatic logic [3:0] coin_value(input logic [1:0] t);
    return t == COIN_1 ? VAL_1 : t == COIN_5 ? VAL_5 : t == COIN_10 ? VAL_10 : 4'd0;
  endfunction
endpackage

// File: rtl/seller_change.sv
// seller_change: greedy change dispenser, one registered coin pulse (10, 5, then 1) per cycle
// Ports: clk/rst_n (async active-low); load_i/amt_i load a new amount; chg_*_o one-hot coin
// pulses; chg_done_o high while the remaining amount is zero.
module seller_change
  import seller_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] amt_i,
  output logic         chg_one_o,
  output logic         chg_five_o,
  output logic         chg_ten_o,
  output logic         chg_done_o
);
  logic [W-1:0] amt_q, amt_d, cur, coin;
  // The first coin is issued on the same edge as the load so pulses line up with CHANGE cycles.
  always_comb begin
    cur = load_i ? amt_i : amt_q;
    coin = cur >= W'(VAL_10) ? W'(VAL_10) : cur >= W'(VAL_5) ? W'(VAL_5) : cur != '0 ? W'(VAL_1) : '0;
    amt_d = cur - coin;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amt_q <= '0;
      chg_one_o <= 1'b0;
      chg_five_o <= 1'b0;
      chg_ten_o <= 1'b0;
    end else begin
      amt_q <= amt_d;
      chg_one_o <= coin == W'(VAL_1);
      chg_five_o <= coin == W'(VAL_5);
      chg_ten_o <= coin == W'(VAL_10);
    end
  end
  assign chg_done_o = amt_q == '0;
endmodule

// File: rtl/seller_ctrl.sv
// seller_ctrl: ticket seller sequencer (request latch, coin credit, ticket pulses, greedy change)
// Ports: sel_*_i request, coin_*_i coin acceptor, cancel_i abort; busy_o, credit_o, ticket_pulse_o,
// chg_{one,five,ten}_o, coin_rej_o, done_o, err_o are all registered.
// Build option: define SELLER_CTRL_TIMEOUT_EN to auto-cancel after TIMEOUT_CYC idle COLLECT cycles.
module seller_ctrl
  import seller_pkg::*;
#(
  parameter int PRICE_W = 4,
  parameter int CREDIT_W = 8,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel_valid_i,
  input  logic [PRICE_W-1:0]  sel_price_i,
  input  logic [1:0]          sel_qty_i,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_type_i,
  input  logic                cancel_i,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                ticket_pulse_o,
  output logic                chg_one_o,
  output logic                chg_five_o,
  output logic                chg_ten_o,
  output logic                coin_rej_o,
  output logic                done_o,
  output logic                err_o
);
  logic [2:0] state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, total_q, total_d, credit_acc, change_amt, amt;
  logic [CREDIT_W:0] sum;
  logic [1:0] qty_q, qty_d;
  logic accept, paid, load, err_d, tmo_hit, chg_done;
  always_comb begin
    // The extra sum bit flags a coin that would push credit past its maximum.
    sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_type_i));
    accept = coin_valid_i && state_q == ST_COLLECT && coin_type_i != COIN_BAD && !sum[CREDIT_W];
    credit_acc = accept ? sum[CREDIT_W-1:0] : credit_q;
    paid = credit_q >= total_q;
    change_amt = credit_q - total_q;
    state_d = state_q;
    credit_d = credit_q;
    total_d = total_q;
    qty_d = qty_q;
    load = 1'b0;
    amt = credit_acc;
    err_d = 1'b0;
    case (state_q)
      ST_IDLE: if (sel_valid_i) begin
        if (sel_price_i != '0 && sel_qty_i != '0) begin
          total_d = CREDIT_W'(sel_price_i) * CREDIT_W'(sel_qty_i);
          qty_d = sel_qty_i;
          credit_d = '0;
          state_d = ST_COLLECT;
        end else err_d = 1'b1;
      end
      ST_COLLECT: begin
        credit_d = credit_acc;
        if (paid) state_d = ST_VEND;
        else if (cancel_i || tmo_hit) begin
          // Refund includes a coin accepted in the same cycle as the cancel.
          err_d = tmo_hit;
          load = credit_acc != '0;
          state_d = load ? ST_CHANGE : ST_DONE;
        end
      end
      ST_VEND: begin
        qty_d = qty_q - 2'd1;
        if (qty_q == 2'd1) begin
          amt = change_amt;
          load = change_amt != '0;
          state_d = load ? ST_CHANGE : ST_DONE;
        end
      end
      ST_CHANGE: state_d = chg_done ? ST_DONE : ST_CHANGE;
      ST_DONE: begin
        credit_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
`ifdef SELLER_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  assign tmo_hit = state_q == ST_COLLECT && !accept && tmo_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= (state_q != ST_COLLECT || accept) ? '0 : tmo_q + TW'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      credit_q <= '0;
      total_q <= '0;
      qty_q <= '0;
      busy_o <= 1'b0;
      ticket_pulse_o <= 1'b0;
      coin_rej_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      total_q <= total_d;
      qty_q <= qty_d;
      busy_o <= state_d != ST_IDLE;
      ticket_pulse_o <= state_d == ST_VEND;
      coin_rej_o <= coin_valid_i && !accept;
      done_o <= state_d == ST_DONE;
      err_o <= err_d;
    end
  end
  assign credit_o = credit_q;
  seller_change #(.W(CREDIT_W)) u_change (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(load),
    .amt_i(amt),
    .chg_one_o(chg_one_o),
    .chg_five_o(chg_five_o),
    .chg_ten_o(chg_ten_o),
    .chg_done_o(chg_done)
  );
endmodule

// File: tb/tb_seller_ctrl.sv
// tb_seller_ctrl: directed self-checking bench for seller_ctrl
module tb_seller_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_valid = 1'b0;
  logic [3:0] sel_price = '0;
  logic [1:0] sel_qty = '0;
  logic coin_valid = 1'b0;
  logic [1:0] coin_type = '0;
  logic cancel = 1'b0;
  logic busy, ticket_pulse, chg_one, chg_five, chg_ten, coin_rej, done, err;
  logic [7:0] credit;
  int checks = 0;
  int failures = 0;
  logic [2:0] seq [16];
  int nseq;
  int tk, o1, o5, o10, cyc;
  bit seen;

  seller_ctrl #(.PRICE_W(4), .CREDIT_W(8), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel_valid_i(sel_valid), .sel_price_i(sel_price), .sel_qty_i(sel_qty),
    .coin_valid_i(coin_valid), .coin_type_i(coin_type), .cancel_i(cancel), .busy_o(busy),
    .credit_o(credit), .ticket_pulse_o(ticket_pulse), .chg_one_o(chg_one), .chg_five_o(chg_five),
    .chg_ten_o(chg_ten), .coin_rej_o(coin_rej), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    sel_valid = 1'b0;
    coin_valid = 1'b0;
    cancel = 1'b0;
    coin_type = 2'b00;
  endtask

  task automatic request(input logic [3:0] p, input logic [1:0] q);
    sel_valid = 1'b1;
    sel_price = p;
    sel_qty = q;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type = t;
    tick();
    coin_valid = 1'b0;
  endtask

  // Observes from the current cycle up to and including the done pulse (bounded).
  task automatic run_to_done(output int t, output int n1, output int n5, output int n10,
                             output int c, output bit s);
    t = 0; n1 = 0; n5 = 0; n10 = 0; c = 0; s = 1'b0; nseq = 0;
    for (int i = 0; i < 40 && !s; i++) begin
      c++;
      t += ticket_pulse ? 1 : 0;
      n1 += chg_one ? 1 : 0;
      n5 += chg_five ? 1 : 0;
      n10 += chg_ten ? 1 : 0;
      if ({chg_ten, chg_five, chg_one} != 3'b000 && nseq < 16) begin
        seq[nseq] = {chg_ten, chg_five, chg_one};
        nseq++;
      end
      if (done) s = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, ticket_pulse, chg_one, chg_five, chg_ten, coin_rej, done, err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=00000000", {busy, ticket_pulse, chg_one, chg_five, chg_ten, coin_rej, done, err});
    end
    checks++;
    if (credit !== 8'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", credit); end
  endtask

  task automatic test_single();
    request(4'd7, 2'd1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
    coin(2'b01);
    checks++;
    if (credit !== 8'd5) begin failures++; $display("FAIL t1_credit5 got=%0d exp=5", credit); end
    coin(2'b01);
    checks++;
    if (credit !== 8'd10 || ticket_pulse !== 1'b0) begin
      failures++; $display("FAIL t1_credit10 got=%0d/%b exp=10/0", credit, ticket_pulse);
    end
    tick();
    checks++;
    if (ticket_pulse !== 1'b1) begin failures++; $display("FAIL t1_vend_latency got=%b exp=1", ticket_pulse); end
    run_to_done(tk, o1, o5, o10, cyc, seen);
    checks++;
    if (!seen || tk != 1 || o1 != 3 || o5 != 0 || o10 != 0 || cyc != 5) begin
      failures++; $display("FAIL t1_seq got=seen%0d tk%0d one%0d five%0d ten%0d cyc%0d exp=seen1 tk1 one3 five0 ten0 cyc5", seen, tk, o1, o5, o10, cyc);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || credit !== 8'd0) begin failures++; $display("FAIL t1_idle got=busy%b credit%0d exp=busy0 credit0", busy, credit); end
  endtask

  task automatic test_multi();
    request(4'd3, 2'd3);
    coin(2'b10);
    checks++;
    if (credit !== 8'd10) begin failures++; $display("FAIL t2_credit got=%0d exp=10", credit); end
    tick();
    cancel = 1'b1;
    run_to_done(tk, o1, o5, o10, cyc, seen);
    cancel = 1'b0;
    checks++;
    if (!seen || tk != 3 || o1 != 1 || o5 != 0 || o10 != 0 || cyc != 5) begin
      failures++; $display("FAIL t2_seq got=seen%0d tk%0d one%0d five%0d ten%0d cyc%0d exp=seen1 tk3 one1 five0 ten0 cyc5", seen, tk, o1, o5, o10, cyc);
    end
    tick();
  endtask

  task automatic test_cancel_refund();
    request(4'd10, 2'd2);
    coin(2'b01);
    cancel = 1'b1;
    coin(2'b10);
    cancel = 1'b0;
    checks++;
    if (credit !== 8'd15 || chg_ten !== 1'b1) begin
      failures++; $display("FAIL t3_cancel got=credit%0d ten%b exp=credit15 ten1", credit, chg_ten);
    end
    run_to_done(tk, o1, o5, o10, cyc, seen);
    checks++;
    if (!seen || tk != 0 || o1 != 0 || o5 != 1 || o10 != 1 || cyc != 3) begin
      failures++; $display("FAIL t3_seq got=seen%0d tk%0d one%0d five%0d ten%0d cyc%0d exp=seen1 tk0 one0 five1 ten1 cyc3", seen, tk, o1, o5, o10, cyc);
    end
    checks++;
    if (nseq != 2 || seq[0] !== 3'b100 || seq[1] !== 3'b010) begin
      failures++; $display("FAIL t3_order got=n%0d %b %b exp=n2 100 010", nseq, seq[0], seq[1]);
    end
    tick();
  endtask

  task automatic test_coin_reject();
    request(4'd7, 2'd1);
    coin(2'b11);
    checks++;
    if (coin_rej !== 1'b1 || credit !== 8'd0) begin
      failures++; $display("FAIL t4_bad_coin got=rej%b credit%0d exp=rej1 credit0", coin_rej, credit);
    end
    coin(2'b10);
    checks++;
    if (coin_rej !== 1'b0 || credit !== 8'd10) begin
      failures++; $display("FAIL t4_good_coin got=rej%b credit%0d exp=rej0 credit10", coin_rej, credit);
    end
    tick();
    coin(2'b01);
    checks++;
    if (coin_rej !== 1'b1 || credit !== 8'd10) begin
      failures++; $display("FAIL t4_vend_coin got=rej%b credit%0d exp=rej1 credit10", coin_rej, credit);
    end
    run_to_done(tk, o1, o5, o10, cyc, seen);
    checks++;
    if (!seen || o1 != 3 || o5 != 0 || cyc != 4) begin
      failures++; $display("FAIL t4_seq got=seen%0d one%0d five%0d cyc%0d exp=seen1 one3 five0 cyc4", seen, o1, o5, cyc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    request(4'd2, 2'd1);
    coin(2'b00);
    coin(2'b00);
    tick();
    run_to_done(tk, o1, o5, o10, cyc, seen);
    checks++;
    if (!seen || tk != 1 || o1 + o5 + o10 != 0 || cyc != 2) begin
      failures++; $display("FAIL t5_exact got=seen%0d tk%0d coins%0d cyc%0d exp=seen1 tk1 coins0 cyc2", seen, tk, o1 + o5 + o10, cyc);
    end
    tick();
    request(4'd5, 2'd1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL t5_b2b_busy got=%b exp=1", busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (done !== 1'b1 || {chg_ten, chg_five, chg_one} !== 3'b000) begin
      failures++; $display("FAIL t5_empty_cancel got=done%b chg%b exp=done1 chg000", done, {chg_ten, chg_five, chg_one});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL t5_idle got=%b exp=0", busy); end
  endtask

  task automatic test_bad_request();
    request(4'd5, 2'd0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL t6_qty0 got=err%b busy%b exp=err1 busy0", err, busy); end
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL t6_err_pulse got=%b exp=0", err); end
    request(4'd0, 2'd2);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL t6_price0 got=err%b busy%b exp=err1 busy0", err, busy); end
    tick();
  endtask

  task automatic test_reset_mid_change();
    request(4'd1, 2'd1);
    coin(2'b10);
    tick();
    tick();
    checks++;
    if (chg_five !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL t7_in_change got=five%b busy%b exp=five1 busy1", chg_five, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ticket_pulse, chg_one, chg_five, chg_ten, coin_rej, done, err} !== 8'h00 || credit !== 8'd0) begin
      failures++; $display("FAIL t7_async_reset got=%b credit%0d exp=00000000 credit0", {busy, ticket_pulse, chg_one, chg_five, chg_ten, coin_rej, done, err}, credit);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, chg_one, chg_five, chg_ten, done} !== 5'b00000) begin
      failures++; $display("FAIL t7_after_reset got=%b exp=00000", {busy, chg_one, chg_five, chg_ten, done});
    end
  endtask

`ifdef SELLER_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    request(4'd9, 2'd1);
    coin(2'b00);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL t8_early got=err%b busy%b exp=err0 busy1", err, busy); end
    tick();
    checks++;
    if (err !== 1'b1 || chg_one !== 1'b1) begin failures++; $display("FAIL t8_timeout got=err%b one%b exp=err1 one1", err, chg_one); end
    run_to_done(tk, o1, o5, o10, cyc, seen);
    checks++;
    if (!seen || tk != 0 || o1 != 1 || cyc != 2) begin
      failures++; $display("FAIL t8_refund got=seen%0d tk%0d one%0d cyc%0d exp=seen1 tk0 one1 cyc2", seen, tk, o1, cyc);
    end
    tick();
  endtask
`endif

  initial begin
    quiet();
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_multi();
    test_cancel_refund();
    test_coin_reject();
    test_back_to_back();
    test_bad_request();
    test_reset_mid_change();
`ifdef SELLER_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/seller_ctrl.md
# seller_ctrl

Sequential transaction controller for the self-service ticket seller. It latches a ticket request (unit price, quantity) and accumulates inserted 1/5/10 coins one event at a time. Once paid, it issues one ticket pulse per ticket, then returns change greedily as single-coin pulses (10s, then 5s, then 1s). It sits between the coin acceptor and the ticket and coin dispensers, and replaces the single-shot combinational pricing path with a cycle-accurate sequencer.

## Interface
- `PRICE_W`, 4: width of the unit-price field.
- `CREDIT_W`, 8: width of the credit register; credit saturates by rejection, never wraps.
- `TIMEOUT_CYC`, 100: idle cycles in COLLECT before auto-cancel; used only with `SELLER_CTRL_TIMEOUT_EN`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel_valid` in 1: request strobe, sampled in IDLE only.
- `sel_price` in PRICE_W: unit price, 1..15.
- `sel_qty` in 2: ticket count, 1..3.
- `coin_valid` in 1: one coin inserted this cycle.
- `coin_type` in 2: 00 = 1, 01 = 5, 10 = 10, 11 = invalid.
- `cancel` in 1: abort request, honoured in COLLECT only.
- `busy` out 1: high in every state except IDLE.
- `credit` out CREDIT_W: current registered credit.
- `ticket_pulse` out 1: one pulse per dispensed ticket.
- `chg_one`, `chg_five`, `chg_ten` out 1 each: one pulse per returned coin.
- `coin_rej` out 1: coin refused, registered one cycle after the offending `coin_valid`.
- `done` out 1: one-cycle end-of-transaction pulse.
- `err` out 1: one-cycle pulse on an invalid request or a timeout.

## Operation
- FSM states: IDLE, COLLECT, VEND, CHANGE, DONE.
- IDLE:
  - `sel_valid` with price ≠ 0 and qty ≠ 0 → latch total = price × qty (6 bits, max 45); clear credit; go to COLLECT.
  - `sel_valid` with price = 0 or qty = 0 → `err` pulse; stay in IDLE.
- COLLECT:
  - Accepted coin: credit ← credit + value.
  - `coin_type` = 11, or credit + value > 2^CREDIT_W − 1 → `coin_rej`; credit unchanged.
  - Registered credit ≥ total → VEND, with the ticket counter loaded from qty.
  - `cancel` → CHANGE with refund = full credit and no tickets.
  - A coin in the same cycle as `cancel` is credited first and is included in the refund.
- VEND: `ticket_pulse` every cycle for qty cycles; change ← credit − total; then CHANGE.
- CHANGE: one coin pulse per cycle, greedy order (10 while change ≥ 10, else 5 while ≥ 5, else 1); change = 0 → DONE. Zero change skips straight to DONE.
- DONE: `done` high for one cycle, credit cleared, → IDLE.
- Coins offered in IDLE, VEND, CHANGE or DONE are rejected via `coin_rej`.
- `cancel` outside COLLECT is ignored.
- Reset mid-transaction: everything returns to IDLE instantly. Credit is lost, no refund pulses are issued, and a ticket or change sequence in progress is aborted.

## Timing
- Reset values: all outputs 0, `credit` 0, state IDLE.
- All outputs are registered.
- `sel_valid` at cycle t → `busy` at t+1.
- Coin at t → `credit` updated at t+1; VEND entered at t+2 if paid. The first `ticket_pulse` is visible at t+2.
- VEND lasts qty cycles.
- CHANGE lasts one cycle per coin returned.
- DONE lasts one cycle; `busy` falls the cycle after `done`.
- Back-to-back transactions: a new `sel_valid` is accepted the first cycle IDLE is re-entered.

## Configuration
- `SELLER_CTRL_TIMEOUT_EN` defined:
  - An idle counter runs in COLLECT and is cleared on entry and on every accepted coin.
  - Reaching `TIMEOUT_CYC` acts as `cancel` (full refund) and pulses `err`.
- Undefined: COLLECT waits indefinitely, no counter is built, and `TIMEOUT_CYC` has no effect.

## Structure
- Package `seller_pkg` holds:
  - the coin-type codes;
  - the coin values 1/5/10;
  - the state enum.
- Sub-module `seller_change`:
  - loads a change amount;
  - emits greedy one-hot coin pulses, one per cycle;
  - raises `chg_done` when the amount reaches 0.
  - Used by CHANGE for both normal change and refunds.

## Test plan
- Price 7, qty 1; coins 5, 5 → credit 10; one `ticket_pulse`; change 3 as `chg_one` ×3; `done`; `busy` low after.
- Price 3, qty 3; coins 10 → VEND; 3 `ticket_pulse`; change 1 as a single `chg_one`; `done`.
- Price 10, qty 2; coin 5, then `cancel` together with a coin 10 → no tickets; refund 15 as `chg_ten` then `chg_five`; `done`.
- `coin_type` = 11 in COLLECT, and any coin 5 during VEND → `coin_rej` one cycle later; credit unchanged.
- `sel_valid` with qty 0 → `err` pulse; remain in IDLE. Then assert `rst_n` low mid-CHANGE → all outputs 0 immediately, IDLE.
- With `SELLER_CTRL_TIMEOUT_EN` and `TIMEOUT_CYC` = 8: coin 1, then 8 idle cycles → `err`; refund 1 via `chg_one`; `done`.
